// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for small OPB slave registers: the two-state
// acknowledge FSM, register word offsets and big-endian/little-endian
// bit-order conversion between OPB [0:31] buses and [31:0] words.
package opb_reg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } opb_state_e;

  // Word offset width: enough for any window the 32-bit address can describe.
  localparam int OFF_W = 30;

  localparam logic [OFF_W-1:0] OFF_DATA   = 30'd0;
  localparam logic [OFF_W-1:0] OFF_COMMIT = 30'd1;

  // OPB bit 0 is the MSB; bit k of the bus becomes bit 31-k of the word.
  function automatic logic [31:0] opb_to_le(input logic [0:31] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[31-k] = v[k];
    return r;
  endfunction

  function automatic logic [0:31] le_to_opb(input logic [31:0] v);
    logic [0:31] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// OPB slave address decode and acknowledge FSM. A hit in IDLE moves to ACK,
// which lasts exactly one cycle; hits are ignored in ACK so a held select
// is acknowledged at most every second cycle.
module opb_slave_decode
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01000700,
  parameter logic [31:0] C_HIGHADDR = 32'h010007FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic             select,
  output logic             take,
  output logic [OFF_W-1:0] offset,
  output logic             xfer_ack
);

  opb_state_e state;
  logic       hit;

  assign hit    = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign offset = OFF_W'((addr - C_BASEADDR) >> 2);
  assign take   = hit && (state == ST_IDLE);

  // IDLE/ACK sequencing with the acknowledge registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      xfer_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state    <= ST_ACK;
            xfer_ack <= 1'b1;
          end
        end
        ST_ACK: begin
          state    <= ST_IDLE;
          xfer_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB software register driving a 32-bit word into user fabric logic.
// Byte-enabled writes update user_data_out and pulse user_data_valid in the
// ack cycle; reads return the current value.
// Optional macro PPC2SIM_SHADOW_EN: offset 0 writes a shadow word and any
// write to offset 1 commits the shadow to user_data_out.
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01000700,
  parameter logic [31:0] C_HIGHADDR   = 32'h010007FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid
);

  logic [31:0]      addr_le;
  logic [31:0]      wdata_le;
  logic [31:0]      active_q;
  logic [31:0]      rd_word;
  logic [31:0]      rdata_p1;
  logic             vld_p1;
  logic             take;
  logic [OFF_W-1:0] offset;
  logic             unused_seq_addr;

  // Replace the lanes of old selected by BE; BE[0] is the most significant byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wr,
                                              input logic [0:3]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[31-8*i -: 8] = wr[31-8*i -: 8];
    return r;
  endfunction

  assign addr_le         = opb_to_le(OPB_ABus);
  assign wdata_le        = opb_to_le(OPB_DBus);
  assign unused_seq_addr = OPB_seqAddr;

  opb_slave_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_decode (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .addr     (addr_le),
    .select   (OPB_select),
    .take     (take),
    .offset   (offset),
    .xfer_ack (Sl_xferAck)
  );

`ifdef PPC2SIM_SHADOW_EN
  logic [31:0] shadow_q;

  // Readback source per offset: shadow at the data slot, live value at commit.
  always_comb begin
    rd_word = '0;
    if (offset == OFF_DATA)        rd_word = shadow_q;
    else if (offset == OFF_COMMIT) rd_word = active_q;
  end

  // p0 -> p1: writes land in the shadow; a commit write publishes it.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      shadow_q <= C_RESET_VAL;
      active_q <= C_RESET_VAL;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      if (take && !OPB_RNW) begin
        if (offset == OFF_DATA) begin
          shadow_q <= merge_bytes(shadow_q, wdata_le, OPB_BE);
        end else if (offset == OFF_COMMIT) begin
          active_q <= shadow_q;
          vld_p1   <= 1'b1;
        end
      end
      if (take && OPB_RNW) rdata_p1 <= rd_word;
    end
  end
`else
  // Readback source per offset: only the data slot is populated.
  always_comb begin
    rd_word = '0;
    if (offset == OFF_DATA)        rd_word = active_q;
    else if (offset == OFF_COMMIT) rd_word = '0;
  end

  // p0 -> p1: data-slot writes go straight to the fabric with a valid pulse.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      active_q <= C_RESET_VAL;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      if (take && !OPB_RNW && (offset == OFF_DATA)) begin
        active_q <= merge_bytes(active_q, wdata_le, OPB_BE);
        vld_p1   <= 1'b1;
      end
      if (take && OPB_RNW) rdata_p1 <= rd_word;
    end
  end
`endif

  assign Sl_DBus         = le_to_opb(rdata_p1);
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = active_q;
  assign user_data_valid = vld_p1;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Bench for opb_register_ppc2simulink: stimulus pushes expected ack-cycle
// responses into a queue; a monitor pops one on every acknowledge.
`timescale 1ns/1ps
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE    = 32'h01000700;
  localparam logic [31:0] HIGH    = 32'h010007FF;
  localparam logic [31:0] RST_VAL = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        err_ack, retry, tout_sup, ack;
  logic [31:0] udata;
  logic        uvalid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] udata;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] m_active = RST_VAL;
  logic [31:0] m_shadow = RST_VAL;
  bit          mon_en = 1'b0;
  logic        prev_ack = 1'b0;

  always #5 clk = ~clk;

  opb_register_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_RESET_VAL  (RST_VAL)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq),
    .Sl_DBus         (sl_dbus),
    .Sl_errAck       (err_ack),
    .Sl_retry        (retry),
    .Sl_toutSup      (tout_sup),
    .Sl_xferAck      (ack),
    .user_data_out   (udata),
    .user_data_valid (uvalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop an expectation on each ack, otherwise bus must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack === 1'b1) begin
        check("no_back_to_back_ack", {31'd0, prev_ack}, 32'd0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: ack=1, expected no ack at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          check("ack_rdata", sl_dbus, mon_e.rdata);
          check("ack_valid", {31'd0, uvalid}, {31'd0, mon_e.valid});
          check("ack_udata", udata, mon_e.udata);
        end
      end else begin
        check("idle_dbus", sl_dbus, 32'd0);
        check("idle_valid", {31'd0, uvalid}, 32'd0);
      end
      check("tied_zero", {29'd0, err_ack, retry, tout_sup}, 32'd0);
      prev_ack = ack;
    end
  end

  // Reference behaviour of one accepted access; returns the ack-cycle view.
  function automatic exp_t predict(input logic [31:0] a, input logic r,
                                   input logic [3:0] b, input logic [31:0] d);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] mask;
    off  = (a - BASE) / 4;
    mask = 32'd0;
    for (int j = 0; j < 4; j++) if (b[j]) mask |= (32'hFF << (8 * j));
    e.rdata = 32'd0;
    e.valid = 1'b0;
    if (r) begin
`ifdef PPC2SIM_SHADOW_EN
      if (off == 0)      e.rdata = m_shadow;
      else if (off == 1) e.rdata = m_active;
`else
      if (off == 0) e.rdata = m_active;
`endif
    end else begin
`ifdef PPC2SIM_SHADOW_EN
      if (off == 0) m_shadow = (m_shadow & ~mask) | (d & mask);
      else if (off == 1) begin
        m_active = m_shadow;
        e.valid  = 1'b1;
      end
`else
      if (off == 0) begin
        m_active = (m_active & ~mask) | (d & mask);
        e.valid  = 1'b1;
      end
`endif
    end
    e.udata = m_active;
    return e;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: %0d acks outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic access(input logic [31:0] a, input logic r, input logic [3:0] b,
                        input logic [31:0] d);
    @(negedge clk);
    abus = a;
    rnw  = r;
    be   = b;
    dbus = d;
    seq  = 1'($urandom);
    sel  = 1'b1;
    if (a >= BASE && a <= HIGH) q.push_back(predict(a, r, b, d));
    @(negedge clk);
    sel  = 1'b0;
    abus = '0;
    dbus = '0;
    wait_drain();
  endtask

  initial begin
    logic [31:0] a;
    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_udata", udata, RST_VAL);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_valid", {31'd0, uvalid}, 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    access(BASE, 1'b0, 4'b1111, 32'h12345678);
    access(BASE, 1'b0, 4'b0101, 32'hAABBCCDD);
`ifndef PPC2SIM_SHADOW_EN
    check("be_merge", udata, 32'h12BB56DD);
`endif
    access(BASE, 1'b1, 4'b1111, 32'h0);
    access(BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
    access(BASE + 32'h10, 1'b0, 4'b1111, 32'hFFFFFFFF);
    access(32'h01000800, 1'b0, 4'b1111, 32'h11111111);
    access(32'h010006FC, 1'b1, 4'b1111, 32'h0);
    access(BASE, 1'b0, 4'b0000, 32'h99999999);
    access(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);

    // Select held for six cycles: three acks, never adjacent.
    @(negedge clk);
    abus = BASE;
    rnw  = 1'b1;
    be   = 4'b1111;
    sel  = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(predict(BASE, 1'b1, 4'b1111, 32'h0));
    repeat (6) @(negedge clk);
    sel = 1'b0;
    wait_drain();

`ifdef PPC2SIM_SHADOW_EN
    a = udata;
    access(BASE, 1'b0, 4'b1111, 32'h00000055);
    check("shadow_hold", udata, a);
    access(BASE + 32'h4, 1'b0, 4'b0000, 32'h0);
    check("shadow_commit", udata, 32'h00000055);
`endif

    // Randomized traffic across hits, unused offsets, commit slot and misses.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       a = BASE + 32'($urandom_range(0, 3));
        1:       a = BASE + 32'h4;
        2:       a = BASE + 32'($urandom_range(0, 255));
        default: a = ($urandom_range(0, 1) == 0) ? HIGH + 32'($urandom_range(1, 64))
                                                 : BASE - 32'($urandom_range(1, 64));
      endcase
      access(a, 1'($urandom), 4'($urandom), $urandom);
    end

    // Reset during the ack cycle clears everything immediately.
    @(negedge clk);
    abus = BASE;
    rnw  = 1'b0;
    be   = 4'b1111;
    dbus = 32'hCAFEF00D;
    sel  = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sel   = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_valid", {31'd0, uvalid}, 32'd0);
    check("midrst_udata", udata, RST_VAL);
    m_active = RST_VAL;
    m_shadow = RST_VAL;
    @(negedge clk);
    rst_n = 1'b1;
    access(BASE, 1'b1, 4'b1111, 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
